microcode_controller: RTL

Microprogrammed control unit for the multicycle RV32I core (lw, sw, R-type, I-type ALU, beq, jal). A microprogram counter (uPC) steps through a control-store ROM, and two dispatch ROMs select the branch target from the opcode. The block drives every datapath select and write enable. It sits between the instruction register / ALU Zero flag and the multicycle datapath, and is the unit the controller test vectors exercise.

---
 rtl/micro_pkg.sv | 61 ++++++
 rtl/microcode_controller_if.sv | 33 +++
 rtl/alu_decoder.sv | 31 +++
 rtl/microcode_controller.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/micro_pkg.sv
// Shared types and encodings for the microprogrammed RV32I controller.
package micro_pkg;

    // Opcodes the controller understands; other values are flagged illegal in Decode.
    typedef enum logic [6:0] {
        OP_LW  = 7'b0000011,
        OP_I   = 7'b0010011,
        OP_SW  = 7'b0100011,
        OP_R   = 7'b0110011,
        OP_BEQ = 7'b1100011,
        OP_JAL = 7'b1101111
    } opcodetype;

    // Microaddresses of the control store; 11..15 are unused.
    typedef enum logic [3:0] {
        U_FETCH     = 4'd0,
        U_DECODE    = 4'd1,
        U_MEMADR    = 4'd2,
        U_MEMREAD   = 4'd3,
        U_MEMWB     = 4'd4,
        U_MEMWRITE  = 4'd5,
        U_EXECUTER  = 4'd6,
        U_ALUWB     = 4'd7,
        U_EXECUTEI  = 4'd8,
        U_JAL       = 4'd9,
        U_BEQ       = 4'd10
    } uaddr_t;

    // Sequencing field: SEQ_FETCH jumps to the word's next field, which is
    // Fetch (0) everywhere except the three words that continue to ALUWB.
    localparam logic [1:0] SEQ_FETCH = 2'b00;
    localparam logic [1:0] SEQ_NEXT  = 2'b01;
    localparam logic [1:0] SEQ_DISP1 = 2'b10;
    localparam logic [1:0] SEQ_DISP2 = 2'b11;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [2:0] ALUC_ADD = 3'b000;
    localparam logic [2:0] ALUC_SUB = 3'b001;
    localparam logic [2:0] ALUC_AND = 3'b010;
    localparam logic [2:0] ALUC_OR  = 3'b011;
    localparam logic [2:0] ALUC_SLT = 3'b101;

    typedef struct packed {
        logic [1:0] alusrca;
        logic [1:0] alusrcb;
        logic [1:0] resultsrc;
        logic       adrsrc;
        logic [1:0] aluop;
        logic       irwrite;
        logic       pcupdate;
        logic       branch;
        logic       regwrite;
        logic       memwrite;
        logic [1:0] seq;
        logic [3:0] next;
    } microword_t;

endpackage

// File: rtl/microcode_controller_if.sv
// Control bundle between the microcode controller and the multicycle datapath.
// There is no handshake: every signal is a level valid for the current cycle.
interface microcode_controller_if;
    import micro_pkg::*;

    opcodetype  op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
    logic [1:0] ImmSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ResultSrc;
    logic       AdrSrc;
    logic [2:0] ALUControl;
    logic       IRWrite;
    logic       PCWrite;
    logic       RegWrite;
    logic       MemWrite;
    logic       IllegalOp;

    modport master (
        input  op, funct3, funct7b5, Zero,
        output ImmSrc, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc, ALUControl,
               IRWrite, PCWrite, RegWrite, MemWrite, IllegalOp
    );

    modport slave (
        output op, funct3, funct7b5, Zero,
        input  ImmSrc, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc, ALUControl,
               IRWrite, PCWrite, RegWrite, MemWrite, IllegalOp
    );
endinterface

// File: rtl/alu_decoder.sv
// Maps the microword ALUOp plus instruction fields to an ALU operation.
module alu_decoder
    import micro_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [2:0] funct3,
    input  logic       op5,
    input  logic       funct7b5,
    output logic [2:0] alucontrol
);

    // Pure decode; subtract only for R-type with bit 30 set.
    always_comb begin
        alucontrol = ALUC_ADD;
        case (aluop)
            ALUOP_ADD: alucontrol = ALUC_ADD;
            ALUOP_SUB: alucontrol = ALUC_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    3'b000:  alucontrol = (op5 & funct7b5) ? ALUC_SUB : ALUC_ADD;
                    3'b010:  alucontrol = ALUC_SLT;
                    3'b110:  alucontrol = ALUC_OR;
                    3'b111:  alucontrol = ALUC_AND;
                    default: alucontrol = ALUC_ADD;
                endcase
            end
            default: alucontrol = ALUC_ADD;
        endcase
    end

endmodule

// File: rtl/microcode_controller.sv
// Microprogrammed control unit: uPC, control store, dispatch ROMs, output decode.
module microcode_controller
    import micro_pkg::*;
#(
    parameter int UPC_W = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    microcode_controller_if.master  bus,
    output logic [UPC_W-1:0]        upc
);

    // Control store; unused addresses give an all-zero word that returns to Fetch.
    function automatic microword_t control_store(input uaddr_t a);
        microword_t w;
        w = '0;
        case (a)
            U_FETCH: begin
                w.irwrite = 1'b1; w.alusrcb = 2'b10; w.resultsrc = 2'b10;
                w.pcupdate = 1'b1; w.seq = SEQ_NEXT;
            end
            U_DECODE: begin
                w.alusrca = 2'b01; w.alusrcb = 2'b01; w.seq = SEQ_DISP1;
            end
            U_MEMADR: begin
                w.alusrca = 2'b10; w.alusrcb = 2'b01; w.seq = SEQ_DISP2;
            end
            U_MEMREAD: begin
                w.adrsrc = 1'b1; w.seq = SEQ_NEXT;
            end
            U_MEMWB: begin
                w.resultsrc = 2'b01; w.regwrite = 1'b1; w.seq = SEQ_FETCH;
            end
            U_MEMWRITE: begin
                w.adrsrc = 1'b1; w.memwrite = 1'b1; w.seq = SEQ_FETCH;
            end
            U_EXECUTER: begin
                w.alusrca = 2'b10; w.alusrcb = 2'b00; w.aluop = ALUOP_FUNCT;
                w.seq = SEQ_FETCH; w.next = U_ALUWB;
            end
            U_EXECUTEI: begin
                w.alusrca = 2'b10; w.alusrcb = 2'b01; w.aluop = ALUOP_FUNCT;
                w.seq = SEQ_FETCH; w.next = U_ALUWB;
            end
            U_JAL: begin
                w.alusrca = 2'b01; w.alusrcb = 2'b10; w.pcupdate = 1'b1;
                w.seq = SEQ_FETCH; w.next = U_ALUWB;
            end
            U_ALUWB: begin
                w.regwrite = 1'b1; w.seq = SEQ_FETCH;
            end
            U_BEQ: begin
                w.alusrca = 2'b10; w.alusrcb = 2'b00; w.aluop = ALUOP_SUB;
                w.branch = 1'b1; w.seq = SEQ_FETCH;
            end
            default: w = '0;
        endcase
        return w;
    endfunction

    // First dispatch, taken from Decode.
    function automatic uaddr_t dispatch1(input opcodetype o);
        case (o)
            OP_LW, OP_SW: return U_MEMADR;
            OP_R:         return U_EXECUTER;
            OP_I:         return U_EXECUTEI;
            OP_JAL:       return U_JAL;
            OP_BEQ:       return U_BEQ;
            default:      return U_FETCH;
        endcase
    endfunction

    function automatic logic dispatch1_legal(input opcodetype o);
        case (o)
            OP_LW, OP_SW, OP_R, OP_I, OP_JAL, OP_BEQ: return 1'b1;
            default:                                  return 1'b0;
        endcase
    endfunction

    // Second dispatch, taken from MemAdr.
    function automatic uaddr_t dispatch2(input opcodetype o);
        case (o)
            OP_LW:   return U_MEMREAD;
            OP_SW:   return U_MEMWRITE;
            default: return U_FETCH;
        endcase
    endfunction

    uaddr_t     upc_q;
    uaddr_t     upc_d;
    microword_t mw;
    logic       active;
    logic [3:0] upc_inc;

    assign active  = reset;
    assign upc_inc = 4'(upc_q) + 4'd1;
    assign upc     = UPC_W'(upc_q);

    // uPC register; reset restarts at Fetch and aborts any instruction.
    always_ff @(posedge clk) begin
        if (!reset) begin
            upc_q <= U_FETCH;
        end else begin
            upc_q <= upc_d;
        end
    end

    // Next-microaddress selection and microword-driven outputs.
    always_comb begin
        mw             = active ? control_store(upc_q) : control_store(U_FETCH);
        upc_d          = U_FETCH;
        bus.ALUSrcA    = mw.alusrca;
        bus.ALUSrcB    = mw.alusrcb;
        bus.ResultSrc  = mw.resultsrc;
        bus.AdrSrc     = mw.adrsrc;
        bus.IRWrite    = active & mw.irwrite;
        bus.PCWrite    = active & (mw.pcupdate | (mw.branch & bus.Zero));
        bus.RegWrite   = active & mw.regwrite;
        bus.MemWrite   = active & mw.memwrite;
        bus.IllegalOp  = active & (upc_q == U_DECODE) & ~dispatch1_legal(bus.op);
        case (mw.seq)
            SEQ_FETCH: upc_d = uaddr_t'(mw.next);
            SEQ_NEXT:  upc_d = uaddr_t'(upc_inc);
            SEQ_DISP1: upc_d = dispatch1(bus.op);
            SEQ_DISP2: upc_d = dispatch2(bus.op);
            default:   upc_d = U_FETCH;
        endcase
    end

    // Immediate format straight from the opcode.
    always_comb begin
        bus.ImmSrc = 2'b00;
        case (bus.op)
            OP_SW:   bus.ImmSrc = 2'b01;
            OP_BEQ:  bus.ImmSrc = 2'b10;
            OP_JAL:  bus.ImmSrc = 2'b11;
            default: bus.ImmSrc = 2'b00;
        endcase
    end

    alu_decoder u_alu_decoder (
        .aluop      (mw.aluop),
        .funct3     (bus.funct3),
        .op5        (bus.op[5]),
        .funct7b5   (bus.funct7b5),
        .alucontrol (bus.ALUControl)
    );

endmodule
